// File: rtl/ps2_msg_pkg.sv
// Shared types and constants for the PS/2 message controller.
package ps2_msg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SEND    = 2'd2
    } msg_state_e;

    localparam int CHAR_W             = 7;
    localparam int DEF_DEPTH          = 16;
    localparam int DEF_TIMEOUT_CYCLES = 50_000_000;

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int len_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ps2_msg_ctrl_buffer.sv
// Message store: DEPTH x CHAR_W register file, synchronous write, asynchronous read.
module msg_buffer
    import ps2_msg_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [CHAR_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [CHAR_W-1:0]        rdata_o
);

    logic [CHAR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ps2_msg_ctrl.sv
// PS/2 message sequencer: capture translated keys between start/end keys, then stream them out.
// Optional capture idle timeout enabled with `define MSG_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | receiver enabled, waiting for the start key
// CAPTURE | storing characters until the end key
// SEND    | streaming the stored message over valid/ready
module ps2_msg_ctrl
    import ps2_msg_pkg::*;
#(
    parameter int DEPTH          = DEF_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valido,
    input  logic [CHAR_W-1:0]            traduccion,
    input  logic                         iniciar,
    input  logic                         terminar,
    output logic                         rx_en,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [CHAR_W-1:0]            rd_data,
    output logic                         rd_last,
    output logic [len_width(DEPTH)-1:0]  msg_len,
    output logic                         busy,
    output logic                         overflow,
    output logic                         timeout
);

    localparam int LW = len_width(DEPTH);
    localparam int AW = $clog2(DEPTH);

    msg_state_e      state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    logic            rx_en_q, busy_q, rd_valid_q;
    logic            buf_we;
    logic [CHAR_W-1:0] buf_rdata;
    logic            tmo_expire;
    logic            last_w;

    msg_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (len_q[AW-1:0]),
        .wdata_i (traduccion),
        .raddr_i (rd_ptr_q),
        .rdata_o (buf_rdata)
    );

`ifdef MSG_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic          timeout_q;

    // Counts silent CAPTURE cycles; any strobe or other state holds it at zero.
    always_comb begin
        idle_cnt_d = '0;
        tmo_expire = 1'b0;
        if (state_q == CAPTURE && !valido) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
            tmo_expire = (idle_cnt_q == IDLE_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= tmo_expire;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign tmo_expire = 1'b0;
    assign timeout    = 1'b0;
`endif

    assign last_w = (state_q == SEND) && (LW'(rd_ptr_q) == len_q - LW'(1));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        buf_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (valido && iniciar) begin
                    state_d    = CAPTURE;
                    len_d      = '0;
                    overflow_d = 1'b0;
                end
            end
            CAPTURE: begin
                if (valido) begin
                    if (iniciar) begin
                        len_d      = '0;
                        overflow_d = 1'b0;
                    end else if (terminar) begin
                        rd_ptr_d = '0;
                        state_d  = (len_q == '0) ? IDLE : SEND;
                    end else if (len_q < LW'(DEPTH)) begin
                        buf_we = 1'b1;
                        len_d  = len_q + 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (tmo_expire) begin
                    state_d = IDLE;
                    len_d   = '0;
                end
            end
            SEND: begin
                if (rd_ready) begin
                    if (last_w) begin
                        state_d  = IDLE;
                        len_d    = '0;
                        rd_ptr_d = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                len_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            rx_en_q    <= 1'b1;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            rx_en_q    <= (state_d != SEND);
            busy_q     <= (state_d != IDLE);
            rd_valid_q <= (state_d == SEND);
        end
    end

    assign rx_en    = rx_en_q;
    assign busy     = busy_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_valid_q ? buf_rdata : '0;
    assign rd_last  = rd_valid_q && last_w;
    assign msg_len  = len_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_msg_ctrl.sv
// Bench for ps2_msg_ctrl: vector table, directed corner sequences and randomized run vs. a queue model.
module tb_ps2_msg_ctrl;

    localparam int DEPTH = 16;
    localparam int TMO   = 10;
    localparam int LW    = $clog2(DEPTH + 1);
`ifdef MSG_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, valido, iniciar, terminar, rd_ready;
    logic [6:0]    traduccion;
    logic          rx_en, rd_valid, rd_last, busy, overflow, timeout;
    logic [6:0]    rd_data;
    logic [LW-1:0] msg_len;

    always #5 clk = ~clk;

    ps2_msg_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .valido(valido), .traduccion(traduccion),
        .iniciar(iniciar), .terminar(terminar), .rx_en(rx_en), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .msg_len(msg_len),
        .busy(busy), .overflow(overflow), .timeout(timeout)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode 0 = waiting, 1 = collecting, 2 = sending.
    int         m_mode = 0;
    logic [6:0] m_msg[$];
    int         m_idx  = 0;
    bit         m_ovf  = 1'b0;
    int         m_idle = 0;
    bit         m_tmo  = 1'b0;
    logic [6:0] got[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit v, input bit ini, input bit ter,
                              input bit rdy, input logic [6:0] ch);
        m_tmo = 1'b0;
        if (rst) begin
            m_mode = 0; m_msg.delete(); m_idx = 0; m_ovf = 1'b0; m_idle = 0;
        end else if (m_mode == 0) begin
            if (v && ini) begin
                m_mode = 1; m_msg.delete(); m_ovf = 1'b0; m_idle = 0;
            end
        end else if (m_mode == 1) begin
            if (v) begin
                m_idle = 0;
                if (ini) begin
                    m_msg.delete(); m_ovf = 1'b0;
                end else if (ter) begin
                    if (m_msg.size() == 0) m_mode = 0;
                    else begin m_mode = 2; m_idx = 0; end
                end else if (m_msg.size() < DEPTH) m_msg.push_back(ch);
                else m_ovf = 1'b1;
            end else if (TMO_EN) begin
                if (m_idle == TMO - 1) begin
                    m_mode = 0; m_msg.delete(); m_tmo = 1'b1; m_idle = 0;
                end else m_idle++;
            end
        end else if (rdy) begin
            if (m_idx == m_msg.size() - 1) begin
                m_mode = 0; m_msg.delete(); m_idx = 0;
            end else m_idx++;
        end
    endtask

    task automatic check_model();
        chk("rx_en", int'(rx_en), int'(m_mode != 2));
        chk("busy", int'(busy), int'(m_mode != 0));
        chk("rd_valid", int'(rd_valid), int'(m_mode == 2));
        chk("rd_data", int'(rd_data), (m_mode == 2) ? int'(m_msg[m_idx]) : 0);
        chk("rd_last", int'(rd_last), int'(m_mode == 2 && m_idx == m_msg.size() - 1));
        chk("msg_len", int'(msg_len), m_msg.size());
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("timeout", int'(timeout), int'(m_tmo));
    endtask

    // One clock: drive inputs, log any transfer, advance model, compare after the edge.
    task automatic cyc(input bit rst, input bit v, input bit ini, input bit ter,
                       input bit rdy, input logic [6:0] ch);
        reset = rst; valido = v; iniciar = ini; terminar = ter;
        rd_ready = rdy; traduccion = ch;
        if (!rst && rd_valid === 1'b1 && rdy) got.push_back(rd_data);
        @(posedge clk);
        model_step(rst, v, ini, ter, rdy, ch);
        #1;
        check_model();
    endtask

    task automatic idle_cyc(input bit rdy);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, rdy, 7'h00);
    endtask

    task automatic chr(input logic [6:0] c);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c);
    endtask

    task automatic start_key();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'h00);
    endtask

    task automatic end_key();
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'h00);
    endtask

    task automatic drain();
        int n = 0;
        while (rd_valid === 1'b1 && n < 4 * DEPTH) begin
            idle_cyc(1'b1);
            n++;
        end
        chk("drain_bound", int'(rd_valid), 0);
    endtask

    task automatic chk_got(input string name, input logic [6:0] exp[$]);
        chk({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk({name, "_char"}, int'(got[i]), int'(exp[i]));
    endtask

    typedef struct {
        bit         v, ini, ter, rdy;
        logic [6:0] ch;
        bit         e_valid;
        logic [6:0] e_data;
        bit         e_last;
        int         e_len;
        bit         e_rx, e_busy;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [6:0] exp_q[$];
        bit         seen_valid;
        int         tmo_at;

        tbl[0] = '{1, 1, 0, 1, 7'h00, 0, 7'h00, 0, 0, 1, 1};
        tbl[1] = '{1, 0, 0, 1, 7'h41, 0, 7'h00, 0, 1, 1, 1};
        tbl[2] = '{1, 0, 0, 1, 7'h42, 0, 7'h00, 0, 2, 1, 1};
        tbl[3] = '{1, 0, 0, 1, 7'h43, 0, 7'h00, 0, 3, 1, 1};
        tbl[4] = '{1, 0, 1, 1, 7'h00, 1, 7'h41, 0, 3, 0, 1};
        tbl[5] = '{0, 0, 0, 1, 7'h00, 1, 7'h42, 0, 3, 0, 1};
        tbl[6] = '{0, 0, 0, 1, 7'h00, 1, 7'h43, 1, 3, 0, 1};
        tbl[7] = '{0, 0, 0, 1, 7'h00, 0, 7'h00, 0, 0, 1, 0};

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
        chk("rst_rx_en", int'(rx_en), 1);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_msg_len", int'(msg_len), 0);

        // Basic three-character message from the vector table
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, tbl[i].v, tbl[i].ini, tbl[i].ter, tbl[i].rdy, tbl[i].ch);
            chk("tbl_valid", int'(rd_valid), int'(tbl[i].e_valid));
            chk("tbl_data", int'(rd_data), int'(tbl[i].e_data));
            chk("tbl_last", int'(rd_last), int'(tbl[i].e_last));
            chk("tbl_len", int'(msg_len), tbl[i].e_len);
            chk("tbl_rx_en", int'(rx_en), int'(tbl[i].e_rx));
            chk("tbl_busy", int'(busy), int'(tbl[i].e_busy));
        end

        // Overflow: 20 characters into a 16-entry buffer
        got.delete(); exp_q.delete();
        start_key();
        for (int i = 0; i < 20; i++) begin
            chr(7'(8'h20 + i));
            if (i < DEPTH) exp_q.push_back(7'(8'h20 + i));
        end
        chk("ovf_set", int'(overflow), 1);
        end_key();
        drain();
        chk_got("ovf_stream", exp_q);
        idle_cyc(1'b0);
        chk("ovf_sticky_idle", int'(overflow), 1);
        start_key();
        chk("ovf_clear_on_start", int'(overflow), 0);
        end_key();
        chk("empty_end_idle", int'(busy), 0);

        // Restart mid-capture, then drain with rd_ready toggling
        got.delete(); exp_q.delete(); exp_q.push_back(7'h5A);
        start_key(); chr(7'h41); start_key(); chr(7'h5A); end_key();
        idle_cyc(1'b0);
        chk("hold_data", int'(rd_data), 'h5A);
        chk("hold_last", int'(rd_last), 1);
        idle_cyc(1'b0);
        chk("hold_data2", int'(rd_data), 'h5A);
        idle_cyc(1'b1);
        chk("restart_done", int'(rd_valid), 0);
        chk_got("restart_stream", exp_q);

        // Start then immediately end: no output ever
        seen_valid = 1'b0;
        start_key(); end_key();
        for (int i = 0; i < 3; i++) begin
            idle_cyc(1'b1);
            if (rd_valid === 1'b1) seen_valid = 1'b1;
        end
        chk("empty_never_valid", int'(seen_valid), 0);

        // Strobes while sending are ignored
        got.delete(); exp_q = '{7'h11, 7'h22, 7'h33};
        start_key(); chr(7'h11); chr(7'h22); chr(7'h33); end_key();
        start_key(); chr(7'h7F); end_key();
        chk("send_ignores_len", int'(msg_len), 3);
        drain();
        chk_got("send_ignore_stream", exp_q);

        // Reset mid-send after two of five characters
        got.delete();
        start_key();
        for (int i = 0; i < 5; i++) chr(7'(8'h61 + i));
        end_key();
        idle_cyc(1'b1); idle_cyc(1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'h00);
        chk("rst_send_valid", int'(rd_valid), 0);
        chk("rst_send_len", int'(msg_len), 0);
        chk("rst_send_rx_en", int'(rx_en), 1);
        chk("rst_send_data", int'(rd_data), 0);
        got.delete(); exp_q = '{7'h30, 7'h31};
        start_key(); chr(7'h30); chr(7'h31); end_key();
        drain();
        chk_got("post_reset_stream", exp_q);

`ifdef MSG_TIMEOUT_EN
        // Capture timeout after ten silent cycles
        tmo_at = 0;
        start_key(); chr(7'h41);
        for (int i = 1; i <= 14; i++) begin
            idle_cyc(1'b0);
            if (timeout === 1'b1 && tmo_at == 0) tmo_at = i;
        end
        chk("tmo_cycle", tmo_at, TMO);
        chk("tmo_idle", int'(busy), 0);
        chk("tmo_len", int'(msg_len), 0);
`else
        tmo_at = 0;
        start_key(); chr(7'h41);
        for (int i = 0; i < 3 * TMO; i++) idle_cyc(1'b0);
        chk("no_tmo_busy", int'(busy), 1);
        chk("no_tmo_len", int'(msg_len), 1);
        end_key();
        drain();
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit rst, v, ini, ter, rdy;
            rst = ($urandom_range(0, 399) == 0);
            v   = ($urandom_range(0, 2) == 0);
            ini = ($urandom_range(0, 19) == 0);
            ter = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            cyc(rst, v, ini, ter, rdy, 7'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
